// File: rtl/demo_scene_sequencer_if.sv
// rtl/demo_scene_sequencer_if.sv - control and output bundle of the demo scene sequencer
//
// Signals:
//   frame_tick  start-of-vblank pulse
//   run         level, 0 freezes the sequencer
//   skip        pulse, ends the current clean scene early
//   user_mask   per-pin enable for the noise mask
//   noise_mask  registered noise mask towards uo_out
//   scene       current scene index
//   scroll_x    horizontal pattern offset
//   reseed      one-cycle PCG seed load strobe
//   seed        PCG seed, valid while reseed is high
//   phase       sequencer state (debug)
// Modports: master drives the controls, slave is the sequencer.

interface demo_scene_sequencer_if;
  logic       frame_tick;
  logic       run;
  logic       skip;
  logic [7:0] user_mask;
  logic [7:0] noise_mask;
  logic [3:0] scene;
  logic [9:0] scroll_x;
  logic       reseed;
  logic [15:0] seed;
  logic [2:0] phase;

  modport master (
    output frame_tick, run, skip, user_mask,
    input  noise_mask, scene, scroll_x, reseed, seed, phase
  );

  modport slave (
    input  frame_tick, run, skip, user_mask,
    output noise_mask, scene, scroll_x, reseed, seed, phase
  );
endinterface

// File: rtl/demo_scene_sequencer.sv
// rtl/demo_scene_sequencer.sv - frame-rate scene scheduler with noise-dissolve transitions
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    demo_scene_sequencer_if.slave (controls in, mask/scene/scroll/seed out)
// Parameters:
//   HOLD_FRAMES  frames a scene is shown clean (1..1023)
//   STEP_FRAMES  frames per mask-bit change during a transition (1..255)
//   NUM_SCENES   number of scenes (2..16)

module demo_scene_sequencer #(
  parameter int HOLD_FRAMES = 120,
  parameter int STEP_FRAMES = 8,
  parameter int NUM_SCENES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  demo_scene_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOLD       = 3'd1,
    NOISE_UP   = 3'd2,
    SWITCH     = 3'd3,
    NOISE_DOWN = 3'd4
  } state_t;

  localparam logic [9:0]  HOLD_LAST  = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0]  STEP_LAST  = 10'(STEP_FRAMES - 1);
  localparam logic [3:0]  SCENE_LAST = 4'(NUM_SCENES - 1);
  localparam logic [15:0] SEED_INIT  = 16'hACE1;
  localparam logic [15:0] SEED_STEP  = 16'h9E37;

  state_t      state, state_n;
  logic [7:0]  fade, fade_n;
  logic [9:0]  frame_cnt, frame_cnt_n;
  logic        skip_pending, skip_pending_n;
  logic [3:0]  scene_q, scene_n;
  logic [15:0] seed_q, seed_n;
  logic [9:0]  scroll_q, scroll_n;
  logic        reseed_q;
  logic [7:0]  mask_q;

  logic        tick_acc;
  logic [7:0]  fade_up, fade_down;

  // SWITCH is a fixed single-cycle state, so a tick landing there is dropped.
  assign tick_acc  = bus.frame_tick && bus.run && (state != SWITCH);
  assign fade_up   = {fade[6:0], 1'b1};
  assign fade_down = {fade[6:0], 1'b0};

  always_comb begin
    state_n        = state;
    fade_n         = fade;
    frame_cnt_n    = frame_cnt;
    scene_n        = scene_q;
    seed_n         = seed_q;
    scroll_n       = scroll_q;
    // skip is latched even while frozen; only IDLE drops it.
    skip_pending_n = skip_pending | (bus.skip && (state != IDLE));

    // Scroll uses the scene shown on this tick; the new scene arrives after SWITCH.
    if (tick_acc && (state != IDLE)) begin
      scroll_n = scroll_q + {6'd0, scene_q} + 10'd1;
    end

    case (state)
      IDLE: begin
        if (tick_acc) begin
          state_n     = HOLD;
          frame_cnt_n = 10'd0;
        end
      end
      HOLD: begin
        fade_n = 8'h00;
        if (tick_acc) begin
          // A skip arriving on the same tick counts immediately.
          if ((frame_cnt == HOLD_LAST) || skip_pending || bus.skip) begin
            state_n        = NOISE_UP;
            frame_cnt_n    = 10'd0;
            skip_pending_n = 1'b0;
          end else begin
            frame_cnt_n = frame_cnt + 10'd1;
          end
        end
      end
      NOISE_UP: begin
        if (tick_acc) begin
          if (frame_cnt == STEP_LAST) begin
            fade_n      = fade_up;
            frame_cnt_n = 10'd0;
            if (fade_up == 8'hFF) begin
              state_n = SWITCH;
            end
          end else begin
            frame_cnt_n = frame_cnt + 10'd1;
          end
        end
      end
      SWITCH: begin
        scene_n     = (scene_q == SCENE_LAST) ? 4'd0 : scene_q + 4'd1;
        seed_n      = seed_q + SEED_STEP;
        state_n     = NOISE_DOWN;
        frame_cnt_n = 10'd0;
      end
      NOISE_DOWN: begin
        if (tick_acc) begin
          if (frame_cnt == STEP_LAST) begin
            fade_n      = fade_down;
            frame_cnt_n = 10'd0;
            if (fade_down == 8'h00) begin
              state_n = HOLD;
            end
          end else begin
            frame_cnt_n = frame_cnt + 10'd1;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        fade_n      = 8'h00;
        frame_cnt_n = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      fade         <= 8'h00;
      frame_cnt    <= 10'd0;
      skip_pending <= 1'b0;
      scene_q      <= 4'd0;
      seed_q       <= SEED_INIT;
      scroll_q     <= 10'd0;
      reseed_q     <= 1'b0;
      mask_q       <= 8'h00;
    end else begin
      state        <= state_n;
      fade         <= fade_n;
      frame_cnt    <= frame_cnt_n;
      skip_pending <= skip_pending_n;
      scene_q      <= scene_n;
      seed_q       <= seed_n;
      scroll_q     <= scroll_n;
      // Registered so the strobe lines up with the new seed and scene.
      reseed_q     <= (state == SWITCH);
      mask_q       <= fade & bus.user_mask;
    end
  end

  assign bus.noise_mask = mask_q;
  assign bus.scene      = scene_q;
  assign bus.scroll_x   = scroll_q;
  assign bus.reseed     = reseed_q;
  assign bus.seed       = seed_q;
  assign bus.phase      = state;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb/tb_demo_scene_sequencer.sv - self-checking bench for demo_scene_sequencer

module tb_demo_scene_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demo_scene_sequencer_if bus();

  demo_scene_sequencer #(
    .HOLD_FRAMES(2),
    .STEP_FRAMES(1),
    .NUM_SCENES (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  scene;
    logic [9:0]  scroll;
    logic        reseed;
    logic [15:0] seed;
  } exp_t;

  typedef struct {
    logic       sk;
    bit         sw;
    logic [2:0] ph;
    logic [7:0] mask;
  } vec_t;

  exp_t sb_q[$];

  logic [3:0]  m_scene;
  logic [9:0]  m_scroll;
  logic [15:0] m_seed;
  bit          m_idle;
  int          m_pulses;

  int   mon_pulses  = 0;
  logic prev_reseed = 1'b0;

  // Every reseed pulse must be exactly one cycle wide.
  always @(negedge clk) begin
    if (bus.reseed === 1'b1) begin
      mon_pulses++;
      chk("reseed_width", 32'(prev_reseed), 32'd0);
    end
    prev_reseed <= bus.reseed;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_scene  = 4'd0;
    m_scroll = 10'd0;
    m_seed   = 16'hACE1;
    m_idle   = 1'b1;
  endtask

  // One frame tick; sw marks the tick that completes the fill to FF.
  task automatic do_tick(input logic sk, input bit sw);
    exp_t e;
    if (bus.run) begin
      if (!m_idle) m_scroll = m_scroll + {6'd0, m_scene} + 10'd1;
      m_idle = 1'b0;
      if (sw) begin
        m_scene = (m_scene == 4'd3) ? 4'd0 : m_scene + 4'd1;
        m_seed  = m_seed + 16'h9E37;
        m_pulses++;
      end
    end
    e.scene  = m_scene;
    e.scroll = m_scroll;
    e.reseed = sw;
    e.seed   = m_seed;
    sb_q.push_back(e);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.skip       = sk;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.skip       = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    chk("scene",    32'(bus.scene),    32'(e.scene));
    chk("scroll_x", 32'(bus.scroll_x), 32'(e.scroll));
    chk("reseed",   32'(bus.reseed),   32'(e.reseed));
    chk("seed",     32'(bus.seed),     32'(e.seed));
    @(negedge clk);
    if (sw) chk("reseed_after", 32'(bus.reseed), 32'd0);
  endtask

  task automatic run_transition();
    for (int i = 0; i < 8; i++) do_tick(1'b0, i == 7);
    chk("fill_mask", 32'(bus.noise_mask), 32'hFF);
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b0);
    chk("back_to_hold", 32'(bus.phase), 32'd1);
    chk("clean_mask", 32'(bus.noise_mask), 32'h00);
  endtask

  vec_t        vt[19];
  logic [15:0] seed_ref[3];
  logic [2:0]  r_phase;
  logic [7:0]  r_mask;
  logic [9:0]  r_scroll;
  int          pulses_before;

  initial begin
    vt[0]  = '{1'b0, 1'b0, 3'd1, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 3'd1, 8'h00};
    vt[2]  = '{1'b0, 1'b0, 3'd2, 8'h00};
    vt[3]  = '{1'b0, 1'b0, 3'd2, 8'h01};
    vt[4]  = '{1'b0, 1'b0, 3'd2, 8'h03};
    vt[5]  = '{1'b0, 1'b0, 3'd2, 8'h07};
    vt[6]  = '{1'b0, 1'b0, 3'd2, 8'h0F};
    vt[7]  = '{1'b0, 1'b0, 3'd2, 8'h1F};
    vt[8]  = '{1'b0, 1'b0, 3'd2, 8'h3F};
    vt[9]  = '{1'b0, 1'b0, 3'd2, 8'h7F};
    vt[10] = '{1'b0, 1'b1, 3'd4, 8'hFF};
    vt[11] = '{1'b0, 1'b0, 3'd4, 8'hFE};
    vt[12] = '{1'b0, 1'b0, 3'd4, 8'hFC};
    vt[13] = '{1'b0, 1'b0, 3'd4, 8'hF8};
    vt[14] = '{1'b0, 1'b0, 3'd4, 8'hF0};
    vt[15] = '{1'b0, 1'b0, 3'd4, 8'hE0};
    vt[16] = '{1'b0, 1'b0, 3'd4, 8'hC0};
    vt[17] = '{1'b0, 1'b0, 3'd4, 8'h80};
    vt[18] = '{1'b0, 1'b0, 3'd1, 8'h00};
    seed_ref[0] = 16'hE94F;
    seed_ref[1] = 16'h8786;
    seed_ref[2] = 16'h25BD;

    // Reset
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.run        = 1'b1;
    bus.skip       = 1'b0;
    bus.user_mask  = 8'hFF;
    m_pulses       = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_noise_mask", 32'(bus.noise_mask), 32'h00);
    chk("rst_scene",      32'(bus.scene),      32'd0);
    chk("rst_scroll_x",   32'(bus.scroll_x),   32'd0);
    chk("rst_seed",       32'(bus.seed),       32'hACE1);
    chk("rst_reseed",     32'(bus.reseed),     32'd0);
    chk("rst_phase",      32'(bus.phase),      32'd0);
    rst_n = 1'b1;

    // Skip in IDLE is dropped: tick 2 must still count in HOLD.
    @(negedge clk);
    bus.skip = 1'b1;
    @(negedge clk);
    bus.skip = 1'b0;

    // Full cycle from the table
    for (int i = 0; i < 19; i++) begin
      do_tick(vt[i].sk, vt[i].sw);
      chk("tbl_phase", 32'(bus.phase),      32'(vt[i].ph));
      chk("tbl_mask",  32'(bus.noise_mask), 32'(vt[i].mask));
    end

    // Scene wrap, seed chain and scroll wrap over many transitions
    for (int c = 0; c < 24; c++) begin
      for (int k = 1; k <= 18; k++) do_tick(1'b0, k == 10);
      chk("scene_seq", 32'(bus.scene), 32'((c + 2) % 4));
      if (c < 3) chk("seed_ref", 32'(bus.seed), 32'(seed_ref[c]));
    end

    // Freeze mid NOISE_UP, with a skip given while frozen
    do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b0);
    chk("frz_enter_up", 32'(bus.phase), 32'd2);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);
    r_phase  = bus.phase;
    r_mask   = bus.noise_mask;
    r_scroll = bus.scroll_x;
    chk("frz_mask_before", 32'(r_mask), 32'h07);
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) do_tick(i == 4, 1'b0);
    chk("frz_phase",  32'(bus.phase),      32'(r_phase));
    chk("frz_mask",   32'(bus.noise_mask), 32'(r_mask));
    chk("frz_scroll", 32'(bus.scroll_x),   32'(r_scroll));
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) do_tick(1'b0, i == 4);
    chk("frz_fill", 32'(bus.noise_mask), 32'hFF);
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b0);
    chk("frz_hold", 32'(bus.phase), 32'd1);
    do_tick(1'b0, 1'b0);
    chk("pending_skip", 32'(bus.phase), 32'd2);
    run_transition();

    // Skip together with a tick at HOLD frame_cnt=0
    do_tick(1'b1, 1'b0);
    chk("skip_same_tick", 32'(bus.phase), 32'd2);
    run_transition();
    do_tick(1'b0, 1'b0);
    chk("skip_cleared", 32'(bus.phase), 32'd1);
    do_tick(1'b0, 1'b0);
    chk("hold_expiry", 32'(bus.phase), 32'd2);

    // Gating by user_mask
    bus.user_mask = 8'h0F;
    for (int i = 0; i < 8; i++) do_tick(1'b0, i == 7);
    chk("gated_mask", 32'(bus.noise_mask), 32'h0F);
    @(negedge clk);
    bus.user_mask = 8'hFF;
    @(negedge clk);
    chk("user_mask_latency", 32'(bus.noise_mask), 32'hFF);
    for (int i = 0; i < 8; i++) do_tick(1'b0, 1'b0);
    chk("gate_hold", 32'(bus.phase), 32'd1);

    // Reset asserted during SWITCH
    do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0);
    chk("pulse_count", 32'(mon_pulses), 32'(m_pulses));
    pulses_before = mon_pulses;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk("switch_phase", 32'(bus.phase), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("sw_rst_scene",  32'(bus.scene),      32'd0);
    chk("sw_rst_seed",   32'(bus.seed),       32'hACE1);
    chk("sw_rst_reseed", 32'(bus.reseed),     32'd0);
    chk("sw_rst_phase",  32'(bus.phase),      32'd0);
    chk("sw_rst_scroll", 32'(bus.scroll_x),   32'd0);
    chk("sw_rst_mask",   32'(bus.noise_mask), 32'h00);
    @(negedge clk);
    chk("sw_rst_reseed2", 32'(bus.reseed), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sw_rst_no_pulse", 32'(mon_pulses), 32'(pulses_before));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
